// File: rtl/int_ctrl.sv
// Interrupt source for cp0 int_i: synchronised hw lines, latched edge requests, Count/Compare timer.
// Latency: irq_raw to int_o is SYNC_STAGES+2 edges; timer asserts on the edge Count reaches Compare.
// Backpressure: none; edge requests stay latched until irq_ack, timer until Compare write or reset.
module int_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] EDGE_MASK   = 6'b000000,
    parameter int         TIMER_LINE  = 5
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [5:0]  irq_raw,
    input  logic [5:0]  irq_ack,
    input  logic        wb_cp0_we,
    input  logic [4:0]  wb_cp0_waddr_0,
    input  logic [4:0]  wb_cp0_waddr_1,
    input  logic [31:0] wb_cp0_wdata_0,
    input  logic [31:0] wb_cp0_wdata_1,
    input  logic        exc_flush_all,
    input  logic [4:0]  ic_raddr,
    output logic [31:0] ic_rdata,
    output logic [7:0]  int_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0]  s;
    logic [5:0]  s_d;
    logic [5:0]  pend;
    logic [5:0]  pend_nxt;
    logic [5:0]  hw_q;
    logic        div;
    logic        tick;
    logic        timer_pending;
    logic [31:0] count;
    logic [31:0] count_inc;
    logic [31:0] compare;

    logic        wr_en;
    logic        cnt_wr;
    logic        cmp_wr;
    logic [31:0] cnt_wdata;
    logic [31:0] cmp_wdata;

    assign s         = sync_q[SYNC_STAGES-1];
    assign tick      = div;
    assign count_inc = count + 32'd1;

    // Edge lines hold until acked; a fresh edge in the ack cycle keeps the request.
    always_comb begin
        pend_nxt = (EDGE_MASK & ((pend & ~irq_ack) | (s & ~s_d))) | (~EDGE_MASK & s);
    end

    // Way 1 overrides way 0 when both target the same register.
    always_comb begin
        wr_en     = wb_cp0_we & ~exc_flush_all;
        cnt_wr    = wr_en & ((wb_cp0_waddr_1 == ADDR_COUNT) | (wb_cp0_waddr_0 == ADDR_COUNT));
        cmp_wr    = wr_en & ((wb_cp0_waddr_1 == ADDR_COMPARE) | (wb_cp0_waddr_0 == ADDR_COMPARE));
        cnt_wdata = (wb_cp0_waddr_1 == ADDR_COUNT) ? wb_cp0_wdata_1 : wb_cp0_wdata_0;
        cmp_wdata = (wb_cp0_waddr_1 == ADDR_COMPARE) ? wb_cp0_wdata_1 : wb_cp0_wdata_0;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            sync_q <= '0;
            s_d    <= '0;
            pend   <= '0;
            hw_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            s_d    <= s;
            pend   <= pend_nxt;
            hw_q   <= pend;
        end
    end

    // div phase matches cp0's Count divider so the mirror never drifts.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            div           <= 1'b0;
            count         <= '0;
            compare       <= '0;
            timer_pending <= 1'b0;
        end else begin
            div <= ~div;
            if (cnt_wr)
                count <= cnt_wdata;
            else if (tick)
                count <= count_inc;
            if (cmp_wr) begin
                compare       <= cmp_wdata;
                timer_pending <= 1'b0;
            end else if (tick && !cnt_wr && (count_inc == compare)) begin
                timer_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        int_o             = {2'b00, hw_q};
        int_o[TIMER_LINE] = hw_q[TIMER_LINE] | timer_pending;
    end

    always_comb begin
        ic_rdata = '0;
        if (rst_) begin
            if (ic_raddr == ADDR_COMPARE)
                ic_rdata = compare;
            else if (ic_raddr == ADDR_COUNT)
                ic_rdata = count;
        end
    end

endmodule
